// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one 16-bit async SRAM between instruction fetch and data access.
// Latency: ack 2*(WAIT_STATES+1)+1 cycles after the IDLE grant cycle; one transaction in flight.
// Backpressure: req/ack level handshake; data wins IDLE arbitration unless fetch has starved STARVE_LIMIT grants.
module sram_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int WAIT_STATES  = 0,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n,
  output logic [15:0]       ram_dout,
  output logic              ram_dout_en,
  input  logic [15:0]       ram_din,
  output logic              busy
);

  localparam int WC_W = 4;
  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(WAIT_STATES);
  localparam logic [WC_W-1:0]   WC_ONE   = WC_W'(1);
  localparam logic [SC_W-1:0]   SC_MAX   = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [WC_W-1:0]     wc_q;
  logic [SC_W-1:0]     starve_q;
  logic                owner_q;     // 1 = data port owns the transaction
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rbuf_q;
  logic [31:0]         if_rdata_q;
  logic [31:0]         mem_rdata_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [15:0]         ram_dout_q;

  logic any_req;
  logic grant_if;
  logic grant_mem;
  logic wc_last;

  // Arbitration: fetch only beats a pending data request once it has been starved STARVE_LIMIT times.
  always_comb begin
    any_req   = if_req | mem_req;
    grant_if  = if_req & (~mem_req | ((STARVE_LIMIT != 0) && (starve_q == SC_MAX)));
    grant_mem = mem_req & ~grant_if;
    wc_last   = (wc_q == WC_LAST);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: each half-word phase is held for WAIT_STATES+1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_HI;
      S_HI:   if (wc_last) state_d = S_LO;
      S_LO:   if (wc_last) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes depend on state and latched direction only, never on live inputs.
  always_comb begin
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_ub_n    = 1'b1;
    ram_lb_n    = 1'b1;
    ram_dout_en = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;
    case (state_q)
      S_HI, S_LO: begin
        ram_ce_n = 1'b0;
        ram_ub_n = 1'b0;
        ram_lb_n = 1'b0;
        if (we_q) begin
          ram_we_n    = 1'b0;
          ram_dout_en = 1'b1;
        end else begin
          ram_oe_n = 1'b0;
        end
      end
      S_ACK: begin
        if_ack  = ~owner_q;
        mem_ack = owner_q;
      end
      default: ;
    endcase
    busy = (state_q != S_IDLE);
  end

  // Datapath: grant latching, wait counting, half-word sequencing and read capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      wc_q        <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wc_q <= '0;
          if (any_req) begin
            owner_q    <= grant_mem;
            we_q       <= grant_mem & mem_we;
            base_q     <= grant_mem ? (mem_addr >> 1) : (if_addr >> 1);
            ram_addr_q <= grant_mem ? (mem_addr >> 1) : (if_addr >> 1);
            wdata_q    <= mem_wdata;
            ram_dout_q <= mem_wdata[31:16];
            if (grant_mem && if_req)
              starve_q <= (starve_q == SC_MAX) ? starve_q : starve_q + SC_ONE;
            else
              starve_q <= '0;
          end
        end
        S_HI: begin
          wc_q <= wc_last ? '0 : wc_q + WC_ONE;
          if (wc_last) begin
            if (!we_q) rbuf_q[31:16] <= ram_din;
            ram_addr_q <= base_q + ADDR_ONE;
            ram_dout_q <= wdata_q[15:0];
          end
        end
        S_LO: begin
          wc_q <= wc_last ? '0 : wc_q + WC_ONE;
          // The owner's result register is loaded here so it is already valid during ACK.
          if (wc_last && !we_q) begin
            rbuf_q[15:0] <= ram_din;
            if (owner_q) mem_rdata_q <= {rbuf_q[31:16], ram_din};
            else         if_rdata_q  <= {rbuf_q[31:16], ram_din};
          end
        end
        default: wc_q <= '0;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single 16-bit external SRAM between the instruction-fetch port and the data-memory port.
- Each 32-bit request becomes two half-word SRAM accesses: high half first, then low half.
- Handshake is req/ack. Data port has priority; a bounded-starvation override protects fetch.
- Sits between the pipeline's fetch/memory stages and the board-level SRAM pins. The top level builds the tristate from ram_dout/ram_dout_en.

Parameters:
- ADDR_W, 18, byte-address width of both ports and of ram_addr
- WAIT_STATES, 0, extra cycles held in each half-word phase (0..15)
- STARVE_LIMIT, 2, consecutive data grants with fetch pending before fetch wins; 0 = strict data priority, no override

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch byte address; bit 0 ignored
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word, held until next fetch completes
- mem_req  in  1  data request, level
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data byte address; bit 0 ignored
- mem_wdata  in  32  write data
- mem_ack  out  1  one-cycle completion pulse
- mem_rdata  out  32  read word, held until next data read completes
- ram_addr  out  ADDR_W  half-word address to SRAM
- ram_ce_n  out  1  chip enable, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, active-low
- ram_ub_n  out  1  upper-byte mask, active-low
- ram_lb_n  out  1  lower-byte mask, active-low
- ram_dout  out  16  write data toward SRAM
- ram_dout_en  out  1  1 = top level drives ram_dout onto the bus
- ram_din  in  16  SRAM read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, HI, LO, ACK. Wait counter wc runs 0..WAIT_STATES in each of HI and LO.
- IDLE arbitration, when any request is high:
  - if_req && mem_req && STARVE_LIMIT != 0 && starve_cnt == STARVE_LIMIT -> grant fetch.
  - Otherwise mem_req -> grant data; else if_req -> grant fetch.
- On grant:
  - Latch owner, we (forced 0 for fetch), base = addr >> 1, and wdata.
  - Go to HI with wc = 0.
  - Later changes to req, addr or wdata are ignored.
- starve_cnt:
  - Data grant with if_req high -> +1, saturating.
  - Data grant with if_req low -> 0.
  - Fetch grant -> 0.
- HI phase:
  - ram_addr = base; ram_ce_n = 0, ram_ub_n = 0, ram_lb_n = 0.
  - Read: ram_oe_n = 0; on the cycle with wc == WAIT_STATES, capture ram_din into rbuf[31:16].
  - Write: ram_we_n = 0, ram_dout = wdata[31:16], ram_dout_en = 1.
  - Advance to LO with wc = 0 after wc == WAIT_STATES.
- LO phase:
  - Same as HI, with ram_addr = base + 1 and the [15:0] halves.
  - base + 1 cannot overflow ADDR_W because base = addr >> 1.
  - Then go to ACK.
- ACK phase:
  - Assert exactly one of if_ack/mem_ack (the owner) for one cycle; all ram strobes inactive.
  - Owner's rdata register is loaded from rbuf so it is valid in that same cycle:
    - fetch -> if_rdata
    - data read -> mem_rdata
    - data write leaves mem_rdata unchanged.
  - Next state IDLE.
- Requester protocol:
  - The requester drops req in the cycle after ack.
  - A req still high in IDLE is a new request.
- Latency: ack in cycle 2*(WAIT_STATES+1)+1 after the IDLE cycle in which the request was granted (3 for WAIT_STATES = 0).
- Peak throughput: one transaction per 2*(WAIT_STATES+1)+2 cycles.
- Idle/outside phases: ram_ce_n = ram_oe_n = ram_we_n = ram_ub_n = ram_lb_n = 1, ram_dout_en = 0, ram_addr holds last value.
- ram_* outputs decode from state/latched registers only; there is no combinational path from any input.
- oe_n and we_n are never both 0 in the same cycle.
- Reset (synchronous, highest priority, any state including mid-phase):
  - Next state IDLE; starve_cnt = 0, wc = 0, rbuf = 0.
  - if_rdata = mem_rdata = 0, ram_addr = 0, ram_dout = 0.
  - All strobes inactive (1), ram_dout_en = 0, acks = 0, busy = 0.
  - An interrupted transaction is dropped with no ack; a partial SRAM write is permitted.

Test Plan:
- Hold reset 2 cycles mid-transaction -> following cycle: all ram strobes 1, ram_dout_en 0, if_ack = mem_ack = 0, if_rdata = mem_rdata = 0, busy 0.
- WAIT_STATES=0, SRAM[0x00040]=0x1234, SRAM[0x00041]=0x5678; if_req with if_addr=0x00080 -> ram_addr 0x00040 (cycle 1), 0x00041 (cycle 2), if_ack in cycle 3, if_rdata=0x12345678, ram_we_n stays 1.
- Data write mem_addr=0x00100, wdata=0xDEADBEEF -> cycle 1: ram_addr 0x080, dout 0xDEAD, we_n 0; cycle 2: ram_addr 0x081, dout 0xBEEF; mem_ack cycle 3. Read back of 0x00100 -> mem_rdata=0xDEADBEEF.
- STARVE_LIMIT=2, if_req and mem_req held continuously (re-raised after each ack) -> grant order mem, mem, fetch, mem, mem, fetch. STARVE_LIMIT=0 -> mem only.
- WAIT_STATES=2 read; ram_din changes during the first two cycles of each phase and is stable on the third -> each phase lasts 3 cycles, ack in cycle 7, only third-cycle values captured.
- Reset asserted in LO of a write -> next cycle IDLE, we_n 1, no mem_ack ever issued, starve_cnt 0, new if_req served normally afterward.
